// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_ctrl
// Purpose  : Bus-mapped multi-channel LED PWM with static/blink/breathe modes.
//            Define LED_PWM_GAMMA_EN for a square-law comparator level.
// Revision : 1.0
// ============================================================================
module led_pwm_ctrl #(
    parameter int NCH      = 3,
    parameter int PWM_BITS = 8,
    parameter int PRE_BITS = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            we,
    input  logic [3:0]      addr,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [NCH-1:0]  pwm_out,
    output logic            frame
);
    localparam logic [PWM_BITS-1:0] C_CNT_MAX      = '1;
    localparam logic [PWM_BITS-1:0] C_LVL_ONE      = PWM_BITS'(1);
    localparam logic [PRE_BITS-1:0] C_PRE_ONE      = PRE_BITS'(1);
    localparam logic [7:0]          C_RATE_ONE     = 8'd1;
    localparam logic [3:0]          C_ADDR_CTRL    = 4'd0;
    localparam logic [3:0]          C_ADDR_STAT    = 4'd15;
    localparam logic [1:0]          C_MODE_BLINK   = 2'd1;
    localparam logic [1:0]          C_MODE_BREATHE = 2'd2;

    logic                 r_en;
    logic [PRE_BITS-1:0]  r_pre;
    logic [PRE_BITS-1:0]  r_pre_cnt;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [NCH-1:0]       r_pwm_out;
    logic [31:0]          r_dout;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_frame;
    logic                 w_step;
    logic [NCH-1:0]       w_hit;
    logic [NCH-1:0][31:0] w_ch_rdata;
    logic [31:0]          w_rdata;
    logic                 w_unused_din;

    assign w_wr         = cs & we;
    assign w_rd         = cs & ~we;
    assign w_frame      = r_en && (r_pwm_cnt == C_CNT_MAX);
    assign w_step       = w_frame && (r_pre_cnt == '0);
    assign w_unused_din = ^din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_pre     <= '0;
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
            r_pwm_out <= '0;
            r_dout    <= '0;
        end else begin
            if (w_wr && (addr == C_ADDR_CTRL)) begin
                r_en  <= din[0];
                r_pre <= din[PRE_BITS+15:16];
            end
            if (r_en) begin
                r_pwm_cnt <= r_pwm_cnt + C_LVL_ONE;
            end
            // PRE is only sampled on reload, so a running countdown is untouched
            if (w_frame) begin
                r_pre_cnt <= (r_pre_cnt == '0) ? r_pre : (r_pre_cnt - C_PRE_ONE);
            end
            r_pwm_out <= r_en ? w_hit : '0;
            if (w_rd) begin
                r_dout <= w_rdata;
            end
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        localparam logic [3:0] C_ADDR = 4'(n + 1);

        logic [PWM_BITS-1:0] r_duty;
        logic [PWM_BITS-1:0] r_lvl;
        logic [1:0]          r_mode;
        logic [7:0]          r_rate;
        logic [7:0]          r_rate_cnt;
        logic                r_dir;      // 1 while breathing downward
        logic                w_sel;
        logic                w_ch_step;
        logic [PWM_BITS-1:0] w_lvl_inc;
        logic [PWM_BITS-1:0] w_lvl_dec;
        logic [PWM_BITS-1:0] w_cmp;
        logic [31:0]         w_rd_word;

        assign w_sel     = w_wr && (addr == C_ADDR);
        assign w_ch_step = w_step && (r_rate_cnt == 8'd0);
        assign w_lvl_inc = r_lvl + C_LVL_ONE;
        assign w_lvl_dec = r_lvl - C_LVL_ONE;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_duty     <= '0;
                r_lvl      <= '0;
                r_mode     <= 2'd0;
                r_rate     <= 8'd0;
                r_rate_cnt <= 8'd0;
                r_dir      <= 1'b0;
            end else if (w_sel) begin
                r_duty     <= din[PWM_BITS-1:0];
                r_mode     <= din[9:8];
                r_rate     <= din[23:16];
                r_rate_cnt <= din[23:16];
                r_lvl      <= '0;
                r_dir      <= 1'b0;
            end else if (w_frame) begin
                if (w_step) begin
                    r_rate_cnt <= (r_rate_cnt == 8'd0) ? r_rate : (r_rate_cnt - C_RATE_ONE);
                end
                case (r_mode)
                    C_MODE_BLINK: begin
                        if (w_ch_step) begin
                            r_lvl <= (r_lvl == '0) ? r_duty : '0;
                        end
                    end
                    C_MODE_BREATHE: begin
                        if (w_ch_step) begin
                            if (r_duty == '0) begin
                                r_lvl <= '0;
                                r_dir <= 1'b0;
                            end else if (!r_dir && (r_lvl < r_duty)) begin
                                r_lvl <= w_lvl_inc;
                                r_dir <= (w_lvl_inc == r_duty);
                            end else if (r_lvl != '0) begin
                                r_lvl <= w_lvl_dec;
                                r_dir <= (w_lvl_dec != '0);
                            end else begin
                                r_lvl <= C_LVL_ONE;
                                r_dir <= 1'b0;
                            end
                        end
                    end
                    default: r_lvl <= r_duty;
                endcase
            end
        end

`ifdef LED_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] w_lvl_ext;
        logic [2*PWM_BITS-1:0] w_sq;
        logic                  w_unused_sq;
        assign w_lvl_ext   = {{PWM_BITS{1'b0}}, r_lvl};
        assign w_sq        = w_lvl_ext * w_lvl_ext;
        assign w_cmp       = w_sq[2*PWM_BITS-1:PWM_BITS];
        assign w_unused_sq = ^w_sq[PWM_BITS-1:0];
`else
        assign w_cmp = r_lvl;
`endif

        assign w_hit[n] = (r_pwm_cnt < w_cmp);

        always_comb begin
            w_rd_word                 = '0;
            w_rd_word[PWM_BITS-1:0]   = r_duty;
            w_rd_word[9:8]            = r_mode;
            w_rd_word[23:16]          = r_rate;
        end
        assign w_ch_rdata[n] = w_rd_word;
    end

    always_comb begin
        w_rdata = '0;
        if (addr == C_ADDR_CTRL) begin
            w_rdata[0]              = r_en;
            w_rdata[PRE_BITS+15:16] = r_pre;
        end else if (addr == C_ADDR_STAT) begin
            w_rdata[PWM_BITS-1:0] = r_pwm_cnt;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (addr == 4'(i + 1)) begin
                    w_rdata = w_ch_rdata[i];
                end
            end
        end
    end

    assign dout    = r_dout;
    assign pwm_out = r_pwm_out;
    assign frame   = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_ctrl
// Purpose  : Directed self-checking bench for led_pwm_ctrl (NCH=3, PWM_BITS=8).
// Revision : 1.0
// ============================================================================
module tb_led_pwm_ctrl;
    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  pwm_out;
    logic        frame;

    int n_cmp = 0;
    int n_err = 0;
    int c0, c1, c2;
    logic [31:0] rd;
    int exp_blink [6];
    int exp_breathe [13];

    led_pwm_ctrl #(.NCH(3), .PWM_BITS(8), .PRE_BITS(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .pwm_out (pwm_out),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High clocks per 256-clock frame for a given level
    function automatic int exp_lvl(input int l);
`ifdef LED_PWM_GAMMA_EN
        return (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge; the access lands on the following posedge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; addr = 4'd0; din = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0; addr = 4'd0;
        d = dout;
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        while (frame !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frame", {31'd0, frame}, 32'd1);
    endtask

    // Starts at a frame negedge, ends at the next one
    task automatic measure(output int h0, output int h1, output int h2);
        int f;
        h0 = 0; h1 = 0; h2 = 0; f = 0;
        repeat (256) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            f  += int'(frame);
        end
        chk("frame_pulses_per_period", f, 1);
        chk("frame_at_period_end", {31'd0, frame}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_blink   = '{0, 255, 255, 0, 0, 255};
        exp_breathe = '{1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};
        reset_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 4'd0; din = 32'd0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_pwm_out", {29'd0, pwm_out}, 32'd0);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_pwm_out", {29'd0, pwm_out}, 32'd0);
        chk("idle_frame", {31'd0, frame}, 32'd0);
        bus_read(4'd1, rd);
        chk("idle_read_ch0", rd, 32'd0);
        bus_read(4'd15, rd);
        chk("idle_stat", rd, 32'd0);

        // Unmapped address ignores writes and reads zero
        bus_write(4'd5, 32'hFFFF_FFFF);
        bus_read(4'd5, rd);
        chk("unmapped_read", rd, 32'd0);

        // CH0 static 64, CH1 blink 255 rate 1, PRE=0
        bus_write(4'd1, 32'h0000_0040);
        bus_write(4'd2, 32'h0001_01FF);
        bus_read(4'd2, rd);
        chk("ch1_readback", rd, 32'h0001_01FF);
        bus_write(4'd0, 32'h0000_0001);
        bus_read(4'd0, rd);
        chk("ctrl_readback", rd, 32'h0000_0001);
        wait_frame();
        for (int k = 0; k < 6; k++) begin
            measure(c0, c1, c2);
            chk($sformatf("static_ch0_high_f%0d", k + 1), c0, exp_lvl(64));
            chk($sformatf("blink_ch1_high_f%0d", k + 1), c1, exp_lvl(exp_blink[k]));
        end

        // Disable with pwm_cnt held at 100, then resume
        repeat (100) @(negedge clk);
        bus_write(4'd0, 32'h0000_0000);
        @(negedge clk);
        chk("dis_pwm_out_low", {29'd0, pwm_out}, 32'd0);
        chk("dis_frame_low", {31'd0, frame}, 32'd0);
        bus_read(4'd15, rd);
        chk("dis_stat", rd, 32'd100);
        repeat (20) @(negedge clk);
        bus_read(4'd15, rd);
        chk("dis_stat_held", rd, 32'd100);
        chk("dis_pwm_out_held_low", {29'd0, pwm_out}, 32'd0);
        bus_write(4'd0, 32'h0000_0001);
        @(negedge clk);
        bus_read(4'd15, rd);
        chk("resume_stat", rd, 32'd101);
        chk("resume_levels_kept", {29'd0, pwm_out}, 32'b010);
        wait_frame();
        measure(c0, c1, c2);
        chk("resume_ch0_high", c0, exp_lvl(64));
        chk("resume_ch1_high", c1, 0);

        // CH2 breathe duty 3 rate 0, PRE=1
        repeat (10) @(negedge clk);
        bus_write(4'd0, 32'h0001_0001);
        bus_write(4'd3, 32'h0000_0203);
        wait_frame();
        for (int k = 0; k < 13; k++) begin
            measure(c0, c1, c2);
            chk($sformatf("breathe_ch2_high_f%0d", k), c2, exp_lvl(exp_breathe[k]));
        end

        // CH0 static 128, then asynchronous reset mid-frame
        repeat (5) @(negedge clk);
        bus_write(4'd1, 32'h0000_0080);
        wait_frame();
        measure(c0, c1, c2);
        chk("static128_ch0_high", c0, exp_lvl(128));
        repeat (10) @(negedge clk);
        chk("pre_reset_ch0_high", {31'd0, pwm_out[0]}, 32'd1);
        bus_read(4'd1, rd);
        chk("pre_reset_dout", rd, 32'h0000_0080);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pwm_out", {29'd0, pwm_out}, 32'd0);
        chk("async_rst_frame", {31'd0, frame}, 32'd0);
        chk("async_rst_dout", dout, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_pwm_out", {29'd0, pwm_out}, 32'd0);
        chk("post_rst_frame", {31'd0, frame}, 32'd0);
        bus_read(4'd0, rd);
        chk("post_rst_ctrl", rd, 32'd0);
        bus_read(4'd15, rd);
        chk("post_rst_stat", rd, 32'd0);
        bus_read(4'd2, rd);
        chk("post_rst_ch1", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Bus-mapped, parametrised multi-channel LED PWM controller for the up5k RISC-V SoC. It replaces the raw GPIO bits that drive the SB_RGBA_DRV PWM inputs. Each channel has its own mode (static, blink, breathe), peak duty and rate. Outputs connect directly to RGBnPWM or any other PWM consumer.

Parameters:
NCH, 3, channel count (1..14).
PWM_BITS, 8, PWM counter and duty resolution (4..12).
PRE_BITS, 16, width of the global frame prescaler.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cs  input  1  bus select, one-cycle strobe
we  input  1  write enable, qualified by cs
addr  input  4  word address
din  input  32  write data
dout  output  32  read data, registered
pwm_out  output  NCH  per-channel PWM outputs
frame  output  1  one-clk pulse at each PWM counter wrap

Behaviour:
- Reset: every register, counter and level is cleared to 0. pwm_out=0, frame=0, dout=0.
- Register map:
  - addr 0 CTRL: [0] EN; [PRE_BITS+15:16] PRE.
  - addr 1..NCH, CHn (channel n=addr-1): [PWM_BITS-1:0] DUTY; [9:8] MODE (0 static, 1 blink, 2 breathe, 3 = static); [23:16] RATE.
  - addr 15 STAT (read-only): [PWM_BITS-1:0] current pwm_cnt.
  - All other addresses read 0; writes to them are ignored.
- Bus timing:
  - Write (cs&we) takes effect on the next clk edge.
  - Read (cs&!we): dout updates on the next edge and holds until the next read.
  - Write and read are never simultaneous (we selects one).
- PWM counter:
  - When EN=1, pwm_cnt increments every clk and wraps from 2^PWM_BITS-1 to 0.
  - frame is asserted in the cycle where pwm_cnt==2^PWM_BITS-1 with EN=1.
  - pwm_out[n] = (pwm_cnt < lvl_n), registered: one clk latency from pwm_cnt to pwm_out.
  - DUTY=0 gives constant low. DUTY=max gives high for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
- Frame prescaler:
  - pre_cnt loads PRE and decrements once per frame.
  - On a frame with pre_cnt==0, it reloads PRE and generates step (so step fires every PRE+1 frames).
- Per-channel rate counter:
  - Loads RATE and decrements on each step.
  - At 0 with step, it reloads and generates ch_step.
- Levels: lvl_n changes only on frame cycles, so there are no mid-period glitches.
  - Static: lvl=DUTY, updated on the next frame.
  - Blink: each ch_step toggles lvl between DUTY and 0.
  - Breathe: each ch_step moves lvl by +/-1. Direction flips to down on reaching DUTY and to up on reaching 0. With DUTY=0, lvl stays 0.
- Writing CHn restarts channel n:
  - rate counter := new RATE, lvl := 0, direction := up.
  - Blink next toggles to DUTY.
  - In static mode, lvl follows on the next frame.
- EN=0:
  - pwm_cnt and pre_cnt are held at their current values.
  - pwm_out is forced low from the next clk; frame=0.
  - Levels and channel state are held. Re-enabling resumes without restart.
- Changing PRE takes effect at the next reload; a running pre_cnt is not disturbed.
- reset_n asserted mid-frame: everything clears immediately (async). Operation resumes with EN=0.

Optional Feature:
Macro LED_PWM_GAMMA_EN.
- Defined: the comparator uses g_n = (lvl_n*lvl_n)>>PWM_BITS instead of lvl_n, giving a square-law perceptual ramp. For PWM_BITS=8: lvl 255 gives 254, lvl 128 gives 64, lvl 15 gives 0. STAT is unaffected.
- Undefined: lvl_n is used directly, with no multiplier inferred.

Test Plan:
- Reset, then idle with EN=0 → pwm_out=0, frame=0, dout=0; a read of addr 1 returns 0.
- CH0 static DUTY=64, EN=1 (NCH=3, PWM_BITS=8) → after the first frame pulse, pwm_out[0] is high for exactly 64 of every 256 clks; frame pulses every 256 clks.
- CH1 blink DUTY=255, RATE=1, PRE=0 → pwm_out[1] alternates between 255/256 high and all-low, toggling every 2 frames (512 clks); the first toggle after the write goes high.
- CH2 breathe DUTY=3, RATE=0, PRE=1 → per-frame levels sampled every 2 frames: 1,2,3,2,1,0,1,… with correct high-clock counts per frame.
- EN cleared mid-frame with pwm_cnt=100 → pwm_out low next clk, STAT reads 100; re-enable → counting resumes at 101 and levels are unchanged.
- With LED_PWM_GAMMA_EN defined, CH0 static DUTY=128 → 64 high clks per 256; assert reset_n low mid-frame → all outputs 0 immediately.
